mirfak_muldiv_ctrl: RTL

Sequencer between the EX stage and the shared iterative multiplier/divider. It accepts M-extension requests from EX and launches the unit with a registered start pulse. It tracks completion, holds the result until EX→WB advances, and aborts the unit on pipeline flush. A one-entry result memo skips recomputation of an identical back-to-back op, and a saturating counter reports muldiv stall cycles.

---
 rtl/mirfak_muldiv_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mirfak_muldiv_ctrl.sv
// Sequencer between EX and the shared iterative mult/div unit: launch, completion tracking,
// result hold until EX->WB advances, flush abort, one-entry result memo and stall counter.
module mirfak_muldiv_ctrl #(
    parameter bit          ENABLE_MEMO = 1'b1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic [2:0]           req_cmd_i,
    input  logic [31:0]          req_op_a_i,
    input  logic [31:0]          req_op_b_i,
    input  logic                 kill_i,
    input  logic                 exwb_enable_i,
    output logic                 busy_o,
    output logic [31:0]          result_o,
    output logic                 result_valid_o,
    output logic                 unit_start_o,
    output logic [2:0]           unit_cmd_o,
    output logic [31:0]          unit_op_a_o,
    output logic [31:0]          unit_op_b_o,
    output logic                 unit_abort_o,
    input  logic                 unit_ack_i,
    input  logic [31:0]          unit_result_i,
    output logic [CNT_WIDTH-1:0] stall_cycles_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CMD_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              memo_valid_q;
    logic [CMD_W-1:0]  memo_cmd_q;
    logic [XLEN-1:0]   memo_a_q;
    logic [XLEN-1:0]   memo_b_q;
    logic [XLEN-1:0]   memo_res_q;

    logic              memo_hit;
    logic              start_d;
    logic              abort_d;
    logic              latch_en;
    logic              load_memo;
    logic              load_unit;
    logic              rv_d;

    // Memo matches only when the incoming op is identical to the last completed one
    assign memo_hit = ENABLE_MEMO && memo_valid_q &&
                      (req_cmd_i == memo_cmd_q) &&
                      (req_op_a_i == memo_a_q) &&
                      (req_op_b_i == memo_b_q);

    assign busy_o = req_i && !kill_i && (state_q != S_HOLD);

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        latch_en  = 1'b0;
        load_memo = 1'b0;
        load_unit = 1'b0;
        rv_d      = result_valid_o;
        case (state_q)
            S_IDLE: begin
                if (req_i && !kill_i) begin
                    if (memo_hit) begin
                        load_memo = 1'b1;
                        rv_d      = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        latch_en  = 1'b1;
                        start_d   = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (kill_i) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (unit_ack_i) begin
                    load_unit = 1'b1;
                    rv_d      = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (exwb_enable_i || kill_i) begin
                    rv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                rv_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Unit interface, result and memo registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            unit_start_o   <= 1'b0;
            unit_abort_o   <= 1'b0;
            unit_cmd_o     <= '0;
            unit_op_a_o    <= '0;
            unit_op_b_o    <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            memo_valid_q   <= 1'b0;
            memo_cmd_q     <= '0;
            memo_a_q       <= '0;
            memo_b_q       <= '0;
            memo_res_q     <= '0;
        end else begin
            unit_start_o   <= start_d;
            unit_abort_o   <= abort_d;
            result_valid_o <= rv_d;
            if (latch_en) begin
                unit_cmd_o  <= req_cmd_i;
                unit_op_a_o <= req_op_a_i;
                unit_op_b_o <= req_op_b_i;
            end
            if (load_memo) begin
                result_o <= memo_res_q;
            end else if (load_unit) begin
                result_o     <= unit_result_i;
                memo_valid_q <= 1'b1;
                memo_cmd_q   <= unit_cmd_o;
                memo_a_q     <= unit_op_a_o;
                memo_b_q     <= unit_op_b_o;
                memo_res_q   <= unit_result_i;
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cycles_o <= '0;
        end else if (busy_o && (stall_cycles_o != {CNT_WIDTH{1'b1}})) begin
            stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(1);
        end
    end

endmodule
